// File: rtl/dcdc_pwm_pkg.sv
// Shared types and constants for the DC-DC PWM gate driver.
package dcdc_pwm_pkg;

  localparam logic [31:0] Q_ONE  = 32'h0001_0000;
  localparam int          Q_FRAC = 16;
  localparam int          CNT_W  = 10;

  typedef enum logic [2:0] {
    S_OFF,
    S_LO,
    S_DT_H,
    S_HI,
    S_DT_L
  } dt_state_e;

  // Compare value for a clamped duty (0..1.0 in Q16.16), truncated toward zero.
  function automatic logic [CNT_W-1:0] duty_to_cmp(input logic [Q_FRAC:0] duty,
                                                   input logic [CNT_W-1:0] period);
    logic [26:0] prod;
    prod = 27'(duty) * 27'(period);
    return prod[Q_FRAC +: CNT_W];
  endfunction

endpackage

// File: rtl/deadtime_gen.sv
// Complementary gate pair with dead-time insertion, driven from the raw PWM level.
//
// state  | meaning
// S_OFF  | disabled, both gates off
// S_LO   | low-side switch on
// S_DT_H | dead-time before high-side turn-on
// S_HI   | high-side switch on
// S_DT_L | dead-time before low-side turn-on
module deadtime_gen
  import dcdc_pwm_pkg::*;
#(
  parameter int unsigned DEADTIME = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  input  logic i_enable,
  output logic o_gate_hi,
  output logic o_gate_lo
);

  localparam int              DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

  dt_state_e       state, state_nxt;
  logic [DT_W-1:0] dt, dt_nxt;

  // Gates are registered from the next state so they never glitch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_OFF;
      dt        <= '0;
      o_gate_hi <= 1'b0;
      o_gate_lo <= 1'b0;
    end else begin
      state     <= state_nxt;
      dt        <= dt_nxt;
      o_gate_hi <= (state_nxt == S_HI);
      o_gate_lo <= (state_nxt == S_LO);
    end
  end

  always_comb begin
    state_nxt = state;
    dt_nxt    = dt;
    if (!i_enable) begin
      state_nxt = S_OFF;
      dt_nxt    = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_nxt = i_raw ? S_DT_H : S_DT_L;
          dt_nxt    = '0;
        end
        S_LO: begin
          if (i_raw) begin
            state_nxt = S_DT_H;
            dt_nxt    = '0;
          end
        end
        S_DT_H: begin
          if (!i_raw)              state_nxt = S_LO;
          else if (dt == DT_LAST)  state_nxt = S_HI;
          else                     dt_nxt    = dt + 1'b1;
        end
        S_HI: begin
          if (!i_raw) begin
            state_nxt = S_DT_L;
            dt_nxt    = '0;
          end
        end
        S_DT_L: begin
          if (i_raw)               state_nxt = S_HI;
          else if (dt == DT_LAST)  state_nxt = S_LO;
          else                     dt_nxt    = dt + 1'b1;
        end
        default: begin
          state_nxt = S_OFF;
          dt_nxt    = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_gate_driver.sv
// Carrier counter, double-buffered duty pipeline and dead-time protected gate pair
// for the synchronous DC-DC converter.
module pwm_gate_driver
  import dcdc_pwm_pkg::*;
#(
  parameter int unsigned PERIOD   = 75,
  parameter int unsigned DEADTIME = 3,
  parameter logic [31:0] DMIN     = 32'h0000_0000,
  parameter logic [31:0] DMAX     = 32'h0000_E666
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [31:0]      i_duty,
  input  logic             i_duty_valid,
  input  logic             i_enable,
  output logic             o_gate_hi,
  output logic             o_gate_lo,
  output logic             o_period_start,
  output logic             o_clamped,
  output logic [CNT_W-1:0] o_cmp_active
);

  // Only the low 17 duty bits reach the multiplier, so the ceiling cannot exceed 1.0.
  localparam logic [31:0]      DMAX_EFF = ($signed(DMAX) > $signed(Q_ONE)) ? Q_ONE : DMAX;
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CMP_RST  = duty_to_cmp(DMIN[Q_FRAC:0], PERIOD_C);

  logic [CNT_W-1:0] cnt;
  logic [Q_FRAC:0]  duty_q;
  logic [Q_FRAC:0]  duty_clamp;
  logic             clamp_hit;
  logic [CNT_W-1:0] cmp_pend;
  logic [CNT_W-1:0] cmp_active;
  logic             wrap;
  logic             raw;

  assign wrap = (cnt == CNT_LAST);
  assign raw  = (cnt < cmp_active);

  always_comb begin
    duty_clamp = i_duty[Q_FRAC:0];
    clamp_hit  = 1'b0;
    if (i_duty[31] || ($signed(i_duty) < $signed(DMIN))) begin
      duty_clamp = DMIN[Q_FRAC:0];
      clamp_hit  = 1'b1;
    end else if ($signed(i_duty) > $signed(DMAX_EFF)) begin
      duty_clamp = DMAX_EFF[Q_FRAC:0];
      clamp_hit  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt            <= '0;
      o_period_start <= 1'b0;
      duty_q         <= DMIN[Q_FRAC:0];
      o_clamped      <= 1'b0;
      cmp_pend       <= CMP_RST;
      cmp_active     <= CMP_RST;
    end else begin
      cnt            <= wrap ? '0 : cnt + 1'b1;
      o_period_start <= wrap;
      if (i_duty_valid) begin
        duty_q    <= duty_clamp;
        o_clamped <= clamp_hit;
      end
      cmp_pend <= duty_to_cmp(duty_q, PERIOD_C);
      // Shadow load only at carrier wrap so a period never sees a torn compare.
      if (wrap) cmp_active <= cmp_pend;
    end
  end

  assign o_cmp_active = cmp_active;

  deadtime_gen #(
    .DEADTIME (DEADTIME)
  ) u_deadtime_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_raw     (raw),
    .i_enable  (i_enable),
    .o_gate_hi (o_gate_hi),
    .o_gate_lo (o_gate_lo)
  );

endmodule

// File: tb/tb_pwm_gate_driver.sv
// Self-checking bench for pwm_gate_driver: duty vector table with a scoreboard, plus
// update-timing, enable and reset sequences.
module tb_pwm_gate_driver;

  localparam int PERIOD = 75;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic [31:0] i_duty = '0;
  logic        i_duty_valid = 1'b0;
  logic        i_enable = 1'b0;
  logic        o_gate_hi, o_gate_lo, o_period_start, o_clamped;
  logic [9:0]  o_cmp_active;

  int total = 0;
  int bad = 0;
  int overlap_cycles = 0;

  typedef struct {
    logic [31:0] duty;
    int          cmp;
    int          clamp;
    int          hi;
    int          lo;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];

  pwm_gate_driver #(
    .PERIOD   (75),
    .DEADTIME (3),
    .DMIN     (32'h0000_0000),
    .DMAX     (32'h0000_E666)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_duty         (i_duty),
    .i_duty_valid   (i_duty_valid),
    .i_enable       (i_enable),
    .o_gate_hi      (o_gate_hi),
    .o_gate_lo      (o_gate_lo),
    .o_period_start (o_period_start),
    .o_clamped      (o_clamped),
    .o_cmp_active   (o_cmp_active)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_gate_hi && o_gate_lo) overlap_cycles++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_period_start && n < 300);
    if (!o_period_start) begin
      total++;
      bad++;
      $display("FAIL %s: no period_start within %0d cycles", name, n);
    end
  endtask

  task automatic strobe(input logic [31:0] d);
    i_duty       = d;
    i_duty_valid = 1'b1;
    @(negedge i_clk);
    i_duty_valid = 1'b0;
  endtask

  // Counts cycles from reset release to the first period_start, noting first lo turn-on.
  task automatic after_release(input string tag);
    int n, first_lo, hi_seen;
    n = 0; first_lo = -1; hi_seen = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (o_gate_lo && first_lo < 0) first_lo = n;
      if (o_gate_hi) hi_seen++;
    end while (!o_period_start && n < 300);
    check({tag, "_first_ps"}, n, PERIOD);
    check({tag, "_first_lo"}, first_lo, 4);
    check({tag, "_hi_idle"}, hi_seen, 0);
  endtask

  initial begin
    vec_t e;
    int   hi_n, lo_n, ov_n, ps_n;

    vecs[0]  = '{32'h0000_8000, 37, 0, 34, 35};
    vecs[1]  = '{32'h0001_0000, 67, 1, 64, 5};
    vecs[2]  = '{32'hFFFF_0000,  0, 1,  0, 75};
    vecs[3]  = '{32'h0000_06D4,  2, 0,  0, 73};
    vecs[4]  = '{32'h0000_4000, 18, 0, 15, 54};
    vecs[5]  = '{32'h0000_E666, 67, 0, 64, 5};
    vecs[6]  = '{32'h0000_E667, 67, 1, 64, 5};
    vecs[7]  = '{32'h0000_0000,  0, 0,  0, 75};
    vecs[8]  = '{32'h0000_0DA8,  4, 0,  1, 68};
    vecs[9]  = '{32'h0000_0A3E,  3, 0,  0, 72};
    vecs[10] = '{32'h7FFF_FFFF, 67, 1, 64, 5};

    #2 i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_gate_hi", int'(o_gate_hi), 0);
    check("rst_gate_lo", int'(o_gate_lo), 0);
    check("rst_period_start", int'(o_period_start), 0);
    check("rst_clamped", int'(o_clamped), 0);
    check("rst_cmp_active", int'(o_cmp_active), 0);

    i_reset_n = 1'b1;
    i_enable  = 1'b1;
    after_release("boot");

    // Table: strobe at cnt 40, expect the new compare from the next wrap.
    foreach (vecs[i]) begin
      wait_ps("sync");
      repeat (40) @(negedge i_clk);
      sb_q.push_back(vecs[i]);
      strobe(vecs[i].duty);
      wait_ps("load");
      e = sb_q.pop_front();
      check($sformatf("v%0d_cmp", i), int'(o_cmp_active), e.cmp);
      check($sformatf("v%0d_clamped", i), int'(o_clamped), e.clamp);
      hi_n = 0; lo_n = 0; ov_n = 0; ps_n = 0;
      for (int k = 0; k < PERIOD; k++) begin
        if (k > 0) @(negedge i_clk);
        hi_n += int'(o_gate_hi);
        lo_n += int'(o_gate_lo);
        ov_n += int'(o_gate_hi & o_gate_lo);
        ps_n += int'(o_period_start);
      end
      check($sformatf("v%0d_hi_cycles", i), hi_n, e.hi);
      check($sformatf("v%0d_lo_cycles", i), lo_n, e.lo);
      check($sformatf("v%0d_overlap", i), ov_n, 0);
      check($sformatf("v%0d_ps_pulses", i), ps_n, 1);
    end

    // Strobe at cnt 73: too late for this wrap, lands one period later.
    wait_ps("s73_sync");
    repeat (73) @(negedge i_clk);
    strobe(32'h0000_8000);
    wait_ps("s73_wrap1");
    check("s73_old_cmp", int'(o_cmp_active), 67);
    check("s73_clamped", int'(o_clamped), 0);
    wait_ps("s73_wrap2");
    check("s73_new_cmp", int'(o_cmp_active), 37);

    // Strobe at cnt 72: exactly two edges before the wrap, applied immediately.
    repeat (72) @(negedge i_clk);
    strobe(32'h0000_4000);
    wait_ps("s72_wrap");
    check("s72_new_cmp", int'(o_cmp_active), 18);

    // Strobe at cnt 74: deferred one period.
    repeat (74) @(negedge i_clk);
    strobe(32'h0000_8000);
    check("s74_wrap_ps", int'(o_period_start), 1);
    check("s74_old_cmp", int'(o_cmp_active), 18);
    wait_ps("s74_wrap2");
    check("s74_new_cmp", int'(o_cmp_active), 37);

    // Two strobes in one period: the later one wins.
    repeat (10) @(negedge i_clk);
    strobe(32'h0001_0000);
    repeat (9) @(negedge i_clk);
    strobe(32'h0000_4000);
    wait_ps("two_wrap");
    check("two_last_cmp", int'(o_cmp_active), 18);
    check("two_last_clamped", int'(o_clamped), 0);

    // Enable drop in S_HI and re-enable with dead-time.
    wait_ps("en_sync");
    repeat (10) @(negedge i_clk);
    check("en_hi_before", int'(o_gate_hi), 1);
    i_enable = 1'b0;
    @(negedge i_clk);
    check("dis_gate_hi", int'(o_gate_hi), 0);
    check("dis_gate_lo", int'(o_gate_lo), 0);
    @(negedge i_clk);
    i_enable = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reen_hi_in_dt", int'(o_gate_hi), 0);
    check("reen_lo_in_dt", int'(o_gate_lo), 0);
    @(negedge i_clk);
    check("reen_hi_after_dt", int'(o_gate_hi), 1);

    // Reset mid-period: gates drop without a clock edge.
    wait_ps("rst_sync");
    repeat (10) @(negedge i_clk);
    check("mid_hi_before", int'(o_gate_hi), 1);
    #1 i_reset_n = 1'b0;
    #1;
    check("mid_rst_gate_hi", int'(o_gate_hi), 0);
    check("mid_rst_gate_lo", int'(o_gate_lo), 0);
    check("mid_rst_cmp", int'(o_cmp_active), 0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    after_release("rerel");

    check("never_overlap", overlap_cycles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_gate_driver.md
# pwm_gate_driver

Downstream consumer of the MPC top level's Q16.16 duty-cycle output. It turns each duty command into a complementary, dead-time-protected gate pair for the synchronous DC-DC converter switches. Duty updates are double-buffered and applied only at carrier wrap. It also emits a period-start strobe so the 15 µs sampler can be phase-locked to the carrier.

## Interface
- PERIOD, 75, carrier period in clock cycles (5 MHz clock → 66.67 kHz); legal range 2..1023
- DEADTIME, 3, dead-time in clock cycles; legal range ≥1
- DMIN, 32'h0000_0000, minimum duty in Q16.16
- DMAX, 32'h0000_E666, maximum duty in Q16.16 (0.9)

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_duty  in  32  signed Q16.16 duty command (the MPC block's o_MPC_DC)
- i_duty_valid  in  1  one-cycle strobe; i_duty is sampled when high
- i_enable  in  1  gate enable; low forces both gates off
- o_gate_hi  out  1  main switch gate
- o_gate_lo  out  1  complementary switch gate
- o_period_start  out  1  one-cycle pulse, high during the cycle in which cnt == 0
- o_clamped  out  1  last accepted duty was outside [DMIN, DMAX]
- o_cmp_active  out  10  compare value in use for the current period

## Operation
- Carrier counter `cnt` (10 b) counts 0..PERIOD-1 and wraps to 0. It is free-running and independent of i_enable.
- Duty pipeline:
  - Stage 1, at the edge where i_duty_valid is high: clamp, then register `duty_q`.
    - A negative value, or a value below DMIN, becomes DMIN.
    - A value above DMAX becomes DMAX.
    - o_clamped is updated on the same edge.
  - Stage 2, next edge: `cmp_pend = (duty_q[16:0] * PERIOD) >> 16`. This is a 27-bit product, truncated. The result lies in 0..PERIOD and needs no rounding.
- Active load: at the edge where cnt goes from PERIOD-1 to 0, `cmp_active <= cmp_pend`. A command therefore takes effect at the first wrap that occurs at least 2 edges after its strobe. Strobes arriving later than that are deferred one period.
- Back-to-back strobes: the last strobe before the load wins.
- Raw PWM signal: `raw = (cnt < cmp_active)`, combinational.
  - cmp 0 → raw is always 0.
  - cmp == PERIOD → raw is always 1.
- Dead-time FSM (registered Moore outputs: hi = 1 only in S_HI, lo = 1 only in S_LO):
  - S_OFF: reset state, both gates 0. Exits when i_enable = 1: to S_DT_H if raw, else to S_DT_L.
  - S_LO: on raw = 1 → S_DT_H with dt = 0.
  - S_DT_H: on raw = 0 → S_LO (abort). On dt == DEADTIME-1 → S_HI. Otherwise dt++.
  - S_HI: on raw = 0 → S_DT_L with dt = 0.
  - S_DT_L: on raw = 1 → S_HI (abort). On dt == DEADTIME-1 → S_LO. Otherwise dt++.
  - Any state with i_enable = 0 → S_OFF. This has priority over every other transition.
- Invariant: o_gate_hi and o_gate_lo are never both 1. Every off→on transition of either gate is preceded by the other gate being off for at least DEADTIME cycles, or by that gate never having been turned on.

## Timing
- Reset values: cnt = 0, duty_q = DMIN, cmp_pend = cmp_active = cmp(DMIN), state = S_OFF.
- All outputs are 0 during reset, except o_cmp_active = cmp(DMIN).
- Reset assertion clears all state asynchronously, so the gates drop immediately, mid-period included.
- Gate latency: each gate lags raw by 1 cycle, plus DEADTIME cycles on turn-on.
- o_period_start is registered (cnt == PERIOD-1). The first pulse comes PERIOD cycles after reset release.
- Input latency: strobe to cmp_pend is 2 edges; strobe to gate effect is at least 2 edges, aligned to the next wrap.

## Structure
- Package dcdc_pwm_pkg holds:
  - Q16.16 constants: Q_ONE = 32'h0001_0000, Q_FRAC = 16.
  - Dead-time state enum: S_OFF, S_LO, S_DT_H, S_HI, S_DT_L.
  - Counter width CNT_W = 10.
- One sub-module, deadtime_gen: inputs are raw, i_enable and DEADTIME; outputs are the gate pair. It contains the FSM only.
- Counter, duty pipeline and shadow load live in pwm_gate_driver.

## Test plan
All cases use PERIOD = 75, DEADTIME = 3, DMAX = 0.9 (32'h0000_E666).
- Duty 0.5 (i_duty = 32'h0000_8000), enabled → cmp 37; per period hi = 34 cycles (cnt 4..37), lo = 35 cycles, both-off 6 cycles, never overlapping.
- Duty 1.0 (32'h0001_0000) → clamped to 58982, cmp 67, o_clamped = 1; hi on 64 cycles per period.
- Negative duty 32'hFFFF_0000 → cmp 0, o_clamped = 1; o_gate_hi never asserts, o_gate_lo is steady 1 after the initial DT_L.
- Minimum pulse: duty 32'h0000_06D4 → cmp 2; DT_H aborts, hi is never asserted, lo drops for exactly 2 cycles per period.
- Update timing:
  - Strobe at cnt = 40 → new cmp_active from the next cnt = 0.
  - Strobe at cnt = 74 → applied one period later.
  - Two strobes in one period → the last one wins.
- Control interruptions:
  - i_enable dropped while in S_HI → both gates 0 the next cycle.
  - On re-enable, the enabled gate asserts only after DEADTIME cycles.
  - i_reset_n asserted mid-period → gates 0 with no clock edge; o_period_start resumes PERIOD cycles after release.
